// File: rtl/verinject_log_pkg.sv
// rtl/verinject_log_pkg.sv - shared widths, field bounds and serialiser phase for the log drain
//
// Purpose: constants and types shared by the log drain top, its FIFO and its stream interface.
// Contents:
//   LOG_REC_W / LOG_BEAT_W  record and beat widths
//   LOG_CYC_* / LOG_XOR_*   bit bounds of the cycle-number and XOR-difference fields
//   log_phase_e             serialiser phase (high beat first, then low beat)
package verinject_log_pkg;

    localparam int LOG_REC_W  = 64;
    localparam int LOG_BEAT_W = 32;

    localparam int LOG_CYC_HI = 63;
    localparam int LOG_CYC_LO = 32;
    localparam int LOG_XOR_HI = 31;
    localparam int LOG_XOR_LO = 0;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } log_phase_e;

endpackage

// File: rtl/log_stream_drain_if.sv
// rtl/log_stream_drain_if.sv - valid/ready beat stream from the log drain to the host driver
//
// Purpose: bundles the outgoing beat stream.
// Signals:
//   m_tvalid  beat available
//   m_tready  consumer accepts the beat
//   m_tdata   beat payload (LOG_BEAT_W bits)
//   m_tlast   marks the low (second) beat of a record
// Modports: master (drain side), slave (consumer side).
interface log_stream_drain_if;
    import verinject_log_pkg::*;

    logic                  m_tvalid;
    logic                  m_tready;
    logic [LOG_BEAT_W-1:0] m_tdata;
    logic                  m_tlast;

    modport master (
        output m_tvalid,
        output m_tdata,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tvalid,
        input  m_tdata,
        input  m_tlast,
        output m_tready
    );

endinterface

// File: rtl/log_sync_fifo.sv
// rtl/log_sync_fifo.sv - single-clock circular FIFO holding whole log records
//
// Purpose: DEPTH-entry storage with wrapping pointers and an explicit occupancy count.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointers and level only)
//   i_push      write i_data at the tail; caller only pushes when not full or popping
//   i_data      record to store
//   i_pop       drop the head; caller only pops when not empty
//   o_head      record at the read pointer
//   o_level     entries held (0..DEPTH)
//   o_full      o_level == DEPTH
//   o_empty     o_level == 0
module log_sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [LW-1:0]    o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;

    // At full with a simultaneous pop, r_wptr == r_rptr: the slot being
    // overwritten is the head that is leaving this same cycle.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_level = r_level;
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/log_stream_drain.sv
// rtl/log_stream_drain.sv - captures 64-bit comparison records and streams them as two 32-bit beats
//
// Purpose: FIFO capture of log_write/log_data records, high-then-low beat serialiser,
// backlog level, sticky overflow and (optionally) a saturating dropped-record counter.
// Optional feature macro: LOG_DROP_CNT_EN builds the drop_count port and counter.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   log_write     record strobe
//   log_data      record: [63:32] cycle number, [31:0] XOR difference
//   m_axis        beat stream (master modport of log_stream_drain_if)
//   level         records held, including one that is half sent
//   overflow      sticky: a record was dropped
//   clear         clears overflow and drop_count
//   drop_count    dropped records, saturating (LOG_DROP_CNT_EN only)
module log_stream_drain
    import verinject_log_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 log_write,
    input  logic [LOG_REC_W-1:0] log_data,
    log_stream_drain_if.master   m_axis,
    output logic [LW-1:0]        level,
    output logic                 overflow,
    input  logic                 clear
`ifdef LOG_DROP_CNT_EN
    ,
    output logic [15:0]          drop_count
`endif
);

    log_phase_e           r_phase;
    logic                 r_overflow;
    logic [LOG_REC_W-1:0] w_head;
    logic [LW-1:0]        w_level;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_valid;
    logic                 w_hs;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    assign w_valid = !w_empty;
    assign w_hs    = w_valid && m_axis.m_tready;
    // A record leaves the FIFO only once its low beat is taken.
    assign w_pop   = w_hs && (r_phase == PH_LO);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign w_push  = log_write && (!w_full || w_pop);
    assign w_drop  = log_write && !w_push;

    log_sync_fifo #(
        .WIDTH (LOG_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (log_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_HI;
        end else if (w_hs) begin
            r_phase <= (r_phase == PH_HI) ? PH_LO : PH_HI;
        end
    end

    // Beat selection uses only the phase register and the stored head, so
    // data is stable under backpressure and m_tready never reaches m_tvalid.
    always_comb begin
        m_axis.m_tdata = '0;
        m_axis.m_tlast = 1'b0;
        if (w_valid) begin
            if (r_phase == PH_HI) begin
                m_axis.m_tdata = w_head[LOG_CYC_HI:LOG_CYC_LO];
            end else begin
                m_axis.m_tdata = w_head[LOG_XOR_HI:LOG_XOR_LO];
                m_axis.m_tlast = 1'b1;
            end
        end
    end

    assign m_axis.m_tvalid = w_valid;
    assign level           = w_level;

    // A drop in the same cycle as clear wins: the new drop must stay visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;

`ifdef LOG_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (clear) begin
            r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_log_stream_drain.sv
// tb/tb_log_stream_drain.sv - scoreboard bench for log_stream_drain with a record-level reference model
module tb_log_stream_drain;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        log_write;
    logic [63:0] log_data;
    logic [LW-1:0] level;
    logic        overflow;
    logic        clear;
`ifdef LOG_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    log_stream_drain_if u_if ();

    log_stream_drain #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .log_write  (log_write),
        .log_data   (log_data),
        .m_axis     (u_if.master),
        .level      (level),
        .overflow   (overflow),
        .clear      (clear)
`ifdef LOG_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    // Reference model: outstanding beats, sticky flag, drop counter.
    int m_beats = 0;
    bit m_ovf   = 1'b0;
    int m_dc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic model_update(input bit wr, input logic [63:0] d, input bit rdy, input bit clr);
        bit hs, pop, acc, drop;
        int lvl;
        hs   = (m_beats > 0) && rdy;
        // An odd number of outstanding beats means the head has only its low beat left.
        pop  = hs && (m_beats % 2 == 1);
        lvl  = (m_beats + 1) / 2;
        acc  = wr && ((lvl < DEPTH) || pop);
        drop = wr && !acc;
        if (acc) begin
            exp_q.push_back('{d: d[63:32], l: 1'b0});
            exp_q.push_back('{d: d[31:0],  l: 1'b1});
        end
        m_beats = m_beats + (acc ? 2 : 0) - (hs ? 1 : 0);
        if (clr) begin
            m_dc = drop ? 1 : 0;
        end else if (drop && m_dc < 65535) begin
            m_dc = m_dc + 1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic step(input bit wr, input logic [63:0] d, input bit rdy, input bit clr);
        log_write     = wr;
        log_data      = wr ? d : 64'h0;
        u_if.m_tready = rdy;
        clear         = clr;
        @(posedge clk);
        model_update(wr, d, rdy, clr);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && m_beats > 0; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_valid", {63'd0, u_if.m_tvalid}, 64'd0);
    endtask

    // Monitor: compares every cycle at the falling edge, away from the active edge.
    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic [32:0] p_beat  = '0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("level", 64'(level), 64'((m_beats + 1) / 2));
            chk("tvalid", {63'd0, u_if.m_tvalid}, {63'd0, m_beats > 0});
            chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
`ifdef LOG_DROP_CNT_EN
            chk("drop_count", 64'(drop_count), 64'(m_dc));
`endif
            if (!u_if.m_tvalid)
                chk("idle_data", {31'd0, u_if.m_tdata, u_if.m_tlast}, 64'd0);
            if (p_valid && !p_ready) begin
                chk("hold_valid", {63'd0, u_if.m_tvalid}, 64'd1);
                chk("hold_data", {31'd0, u_if.m_tdata, u_if.m_tlast}, {31'd0, p_beat});
            end
            if (u_if.m_tvalid && u_if.m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {31'd0, u_if.m_tdata, u_if.m_tlast}, 64'hDEAD);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat", {31'd0, u_if.m_tdata, u_if.m_tlast}, {31'd0, e.d, e.l});
                end
            end
            p_valid = u_if.m_tvalid;
            p_ready = u_if.m_tready;
            p_beat  = {u_if.m_tdata, u_if.m_tlast};
        end else begin
            p_valid = 1'b0;
        end
    end

    initial begin
        rst_n         = 1'b0;
        log_write     = 1'b0;
        log_data      = 64'h0;
        clear         = 1'b0;
        u_if.m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", {63'd0, u_if.m_tvalid}, 64'd0);
        chk("rst_data", {31'd0, u_if.m_tdata, u_if.m_tlast}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        rst_n = 1'b1;

        // Single record, consumer always ready.
        step(1'b1, 64'h0000_0005_0000_0100, 1'b1, 1'b0);
        chk("single_hi", {31'd0, u_if.m_tdata, u_if.m_tlast}, {31'd0, 32'h5, 1'b0});
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("single_lo", {31'd0, u_if.m_tdata, u_if.m_tlast}, {31'd0, 32'h100, 1'b1});
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("single_done", {63'd0, u_if.m_tvalid}, 64'd0);
        drain();

        // Backpressure for five cycles.
        step(1'b1, 64'hCAFE_0001_1234_5678, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 64'h0, 1'b0, 1'b0);
            chk("bp_hold", {31'd0, u_if.m_tdata, u_if.m_tlast}, {31'd0, 32'hCAFE_0001, 1'b0});
        end
        drain();

        // Overfill by one, then push at full alongside the low-beat handshake.
        for (int i = 0; i < 17; i++) step(1'b1, {32'(i + 1), $urandom}, 1'b0, 1'b0);
        chk("fill_level", 64'(level), 64'd16);
        chk("fill_overflow", {63'd0, overflow}, 64'd1);
`ifdef LOG_DROP_CNT_EN
        chk("fill_drop_count", 64'(drop_count), 64'd1);
`endif
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b1, 64'hBEEF_0000_0000_0042, 1'b1, 1'b0);
        chk("full_push_level", 64'(level), 64'd16);
        drain();

        // Clear coincident with a drop, then clear alone.
        for (int i = 0; i < 16; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        step(1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b1);
        chk("clr_drop_overflow", {63'd0, overflow}, 64'd1);
`ifdef LOG_DROP_CNT_EN
        chk("clr_drop_count", 64'(drop_count), 64'd1);
`endif
        step(1'b0, 64'h0, 1'b0, 1'b1);
        chk("clr_overflow", {63'd0, overflow}, 64'd0);
        chk("clr_level", 64'(level), 64'd16);
        drain();

        // Reset while the head is half sent.
        for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        u_if.m_tready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, u_if.m_tvalid}, 64'd0);
        chk("midrst_level", 64'(level), 64'd0);
        m_beats = 0;
        m_ovf   = 1'b0;
        m_dc    = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("postrst_valid", {63'd0, u_if.m_tvalid}, 64'd0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 60, {$urandom, $urandom},
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
